// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// memory strobe polarity.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_e;

  // Stores have no unsigned variants, so anything above SW is illegal.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3 > F3_W;
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte/half lane steering: load extraction with sign/zero extension, and the
// store merge used for read-modify-write of sub-word stores.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign half_sel = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // NOTE: the whole-word default comes first so every path assigns store_word and no latch is inferred.
  always_comb begin
    store_word = rd_word;
    case (funct3)
      F3_B:    store_word[{lane, 3'b000} +: 8]    = wdata[7:0];
      F3_H:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// RV32I load/store initiator for a word-wide, write-low, combinational-read
// data memory; sub-word stores are done as read-modify-write.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_r_wr,
  output logic [ADDR_W-1:0] mem_daddr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          lane_q, lane_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_r_wr_q, mem_r_wr_d;
  logic [ADDR_W-1:0]   mem_daddr_q, mem_daddr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                misaligned, out_of_range, req_err;
  logic [DATA_W-1:0]   load_data, store_word;

  assign misaligned   = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
  assign out_of_range = |req_addr[31:ADDR_W+2];
  assign req_err      = misaligned || out_of_range || f3_illegal(req_we, req_funct3);

  // The word is taken straight off the combinational read port during ACCESS
  // and lands in rsp_rdata_q (loads) or mem_din_q (stores) on the same edge.
  lsu_lane_fmt u_lane_fmt (
    .rd_word    (mem_dout),
    .wdata      (wdata_q),
    .lane       (lane_q),
    .funct3     (f3_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mem_r_wr_d  = MEM_READ;
    mem_daddr_d = mem_daddr_q;
    mem_din_d   = mem_din_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          if (req_err) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else begin
            mem_daddr_d = req_addr[ADDR_W+1:2];
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          mem_din_d  = store_word;
          mem_r_wr_d = MEM_WRITE;
          state_d    = WRITE;
        end else begin
          rsp_rdata_d = load_data;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end
      end
      WRITE: begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      lane_q      <= 2'd0;
      wdata_q     <= '0;
      mem_r_wr_q  <= MEM_READ;
      mem_daddr_q <= '0;
      mem_din_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      mem_r_wr_q  <= mem_r_wr_d;
      mem_daddr_q <= mem_daddr_d;
      mem_din_q   <= mem_din_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign mem_r_wr  = mem_r_wr_q;
  assign mem_daddr = mem_daddr_q;
  assign mem_din   = mem_din_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  a_write_only_in_write: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_r_wr_q == MEM_WRITE) |-> (state_q == WRITE));

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: directed vector table, reset and
// backpressure sequences, then random requests against a byte-level model.
module tb_lsu_dmem_ctrl;
  import lsu_pkg::*;

  localparam int ADDR_W = 10;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic              mem_r_wr;
  logic [ADDR_W-1:0] mem_daddr;
  logic [31:0]       mem_din, mem_dout;

  lsu_dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_r_wr   (mem_r_wr),
    .mem_daddr  (mem_daddr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  // NOTE: memory arrays are not reset; both copies are seeded once at time 0 instead.
  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];

  assign mem_dout = mem[mem_daddr];
  always @(posedge clk) if (mem_r_wr == 1'b0) mem[mem_daddr] <= mem_din;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } res_t;

  // Byte-addressed reference: size from funct3, shifts and masks on a 64-bit value.
  function automatic res_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    res_t r;
    int unsigned nbytes, sh, idx;
    longint unsigned w, v, lane_mask;
    bit illegal;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    nbytes  = 1 << (f3 % 4);
    r.err   = illegal || (addr % nbytes != 0) || (addr >= 4 * WORDS);
    r.rdata = 32'h0;
    if (r.err) return r;
    idx       = addr / 4;
    sh        = 8 * (addr % 4);
    w         = ref_mem[idx];
    lane_mask = (64'd1 << (8 * nbytes)) - 1;
    if (!we) begin
      v = (w >> sh) & lane_mask;
      if (f3 < 3'd4 && nbytes < 4 && v >= (64'd1 << (8 * nbytes - 1)))
        v = v - (64'd1 << (8 * nbytes));
      r.rdata = v[31:0];
    end else begin
      v = (w & ~(lane_mask << sh)) | ((longint'(wdata) & lane_mask) << sh);
      ref_mem[idx] = v[31:0];
    end
    return r;
  endfunction

  task automatic wait_idle(input string name);
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({name, " ready"}, {31'h0, req_ready}, 32'h1);
  endtask

  // One request; cycle k is the k-th negedge after the accept edge.
  task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int lat, writes, exp_lat;
    logic [31:0] got_rdata, got_daddr;
    logic got_err;
    exp_lat = exp_err ? 1 : (we ? 3 : 2);
    wait_idle(name);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    lat = 0; writes = 0; got_rdata = 32'h0; got_err = 1'b0; got_daddr = 32'h0;
    for (int k = 1; k <= 8 && (lat == 0 || k <= lat + 1); k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        got_daddr = 32'(mem_daddr);
      end
      if (mem_r_wr == 1'b0) writes++;
      if (lat == 0 && rsp_valid) begin
        lat = k; got_rdata = rsp_rdata; got_err = rsp_err;
      end else if (lat != 0) begin
        check({name, " pulse"}, {31'h0, rsp_valid}, 32'h0);
        check({name, " hold"}, rsp_rdata, exp_rdata);
      end
    end
    req_valid = 1'b0;
    check({name, " latency"}, lat, exp_lat);
    check({name, " rdata"}, got_rdata, exp_rdata);
    check({name, " err"}, {31'h0, got_err}, {31'h0, exp_err});
    check({name, " writes"}, writes, (!exp_err && we) ? 1 : 0);
    if (!exp_err) check({name, " daddr"}, got_daddr, {22'h0, addr[ADDR_W+1:2]});
  endtask

  // req_valid held high across several transactions of the same request.
  task automatic hold_stream(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata, input int period);
    res_t r;
    int accepts = 0, rsps = 0, writes = 0;
    r = model(we, f3, addr, wdata);
    wait_idle(name);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int c = 0; c < 4 * period; c++) begin
      check($sformatf("%s ready c%0d", name, c), {31'h0, req_ready}, {31'h0, (c % period == 0)});
      if (req_ready) accepts++;
      if (rsp_valid) begin
        rsps++;
        check($sformatf("%s rdata c%0d", name, c), rsp_rdata, r.rdata);
      end
      if (mem_r_wr == 1'b0) writes++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check({name, " accepts"}, accepts, 4);
    check({name, " responses"}, rsps, 4);
    check({name, " writes"}, writes, we ? 4 : 0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [17];

  initial begin
    res_t r;
    logic [31:0] old_word;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;

    vecs[0]  = '{1'b1, F3_W,  32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, F3_W,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, F3_W,  32'h10,   32'h11223344, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, F3_B,  32'h13,   32'h000000A5, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, F3_W,  32'h10,   32'h0,        32'hA5223344, 1'b0};
    vecs[5]  = '{1'b0, F3_B,  32'h13,   32'h0,        32'hFFFFFFA5, 1'b0};
    vecs[6]  = '{1'b0, F3_BU, 32'h13,   32'h0,        32'h000000A5, 1'b0};
    vecs[7]  = '{1'b1, F3_W,  32'h0,    32'h11223344, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, F3_H,  32'h0,    32'h00008001, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, F3_W,  32'h0,    32'h0,        32'h11228001, 1'b0};
    vecs[10] = '{1'b0, F3_H,  32'h0,    32'h0,        32'hFFFF8001, 1'b0};
    vecs[11] = '{1'b0, F3_HU, 32'h2,    32'h0,        32'h00001122, 1'b0};
    vecs[12] = '{1'b0, F3_W,  32'h2,    32'h0,        32'h00000000, 1'b1};
    vecs[13] = '{1'b1, F3_H,  32'h5,    32'h0000BEEF, 32'h00000000, 1'b1};
    vecs[14] = '{1'b0, 3'd3,  32'h0,    32'h0,        32'h00000000, 1'b1};
    vecs[15] = '{1'b1, F3_W,  32'h1000, 32'h12345678, 32'h00000000, 1'b1};
    vecs[16] = '{1'b0, F3_W,  32'h10,   32'h0,        32'hA5223344, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    repeat (2) @(negedge clk);
    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset mem_r_wr", {31'h0, mem_r_wr}, 32'h1);
    check("reset mem_daddr", {22'h0, mem_daddr}, 32'h0);
    check("reset mem_din", mem_din, 32'h0);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'h0, rsp_err}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      void'(model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata));
      run_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Reset while WRITE is active: the write strobe drops at once and nothing commits.
    old_word = ref_mem[20];
    wait_idle("rst_a");
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h50; req_wdata = ~old_word;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("rst_a in write", {31'h0, mem_r_wr}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("rst_a async r_wr", {31'h0, mem_r_wr}, 32'h1);
    check("rst_a idle", {31'h0, req_ready}, 32'h1);
    check("rst_a rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_a word kept", mem[20], old_word);
    @(negedge clk);
    check("rst_a no rsp", {31'h0, rsp_valid}, 32'h0);

    // Reset after the commit edge: the write stays, the response is lost.
    void'(model(1'b1, F3_W, 32'h54, 32'hCAFEF00D));
    wait_idle("rst_b");
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h54; req_wdata = 32'hCAFEF00D;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_b in resp", {31'h0, rsp_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_b rsp dropped", {31'h0, rsp_valid}, 32'h0);
    check("rst_b word", mem[21], 32'hCAFEF00D);
    @(negedge clk);
    rst_n = 1'b1;

    hold_stream("bp_load", 1'b0, F3_W, 32'h10, 32'h0, 3);
    hold_stream("bp_store", 1'b1, F3_B, 32'h21, 32'h0000005A, 4);
    run_req("bp_store readback", 1'b0, F3_BU, 32'h21, 32'h0, {24'h0, 8'h5A}, 1'b0);

    for (int i = 0; i < 300; i++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wdata = $urandom;
      r = model(we, f3, addr, wdata);
      run_req($sformatf("rand%0d", i), we, f3, addr, wdata, r.rdata, r.err);
    end

    for (int i = 0; i < WORDS; i += 37)
      check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Load/store initiator placed between the execute stage and the word-wide data memory (write-low r_wr, combinational read, whole-word writes only). It accepts RV32I load/store requests and checks alignment and range. It drives the memory's r_wr/daddr/din, sign- or zero-extends load data, and performs read-modify-write for SB/SH, since the memory has no byte enables.

Parameters:
ADDR_W, 10, memory word-index width; mem_daddr = req_addr[ADDR_W+1:2]
DATA_W, 32, data width; fixed at 32

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2)
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits used for SB/SH)
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  valid with rsp_valid; misaligned, illegal funct3 or out of range
mem_r_wr  out  1  to memory: 1=read, 0=write
mem_daddr  out  ADDR_W  word index to memory
mem_din  out  32  write data to memory
mem_dout  in  32  combinational read data from memory

Behaviour:
- FSM states: IDLE, ACCESS, WRITE, RESP. All outputs are registered or decoded from state.
- Reset (async, rst_n=0): state=IDLE, mem_r_wr=1, mem_daddr=0, mem_din=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. mem_r_wr goes to 1 immediately, without a clock edge.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata and evaluate the error:
  - misaligned: H with addr[0]≠0, W with addr[1:0]≠0
  - illegal funct3: loads 3/6/7, stores ≥3
  - out of range: req_addr[31:ADDR_W+2]≠0
  - error → RESP with rsp_err=1. No memory write ever occurs.
  - otherwise → ACCESS, with mem_daddr=addr[ADDR_W+1:2].
- ACCESS (mem_r_wr=1): capture mem_dout into a word register.
  - Load: select lane by addr[1:0], little-endian (byte lane k = bits 8k+7:8k; half lane = addr[1]). Extend: LB/LH sign, LBU/LHU zero, LW pass. Then → RESP.
  - SW: mem_din=wdata.
  - SB: mem_din = captured word with byte lane replaced by wdata[7:0].
  - SH: mem_din = captured word with half lane replaced by wdata[15:0].
  - Any store → WRITE.
- WRITE: mem_r_wr=0 for exactly one cycle, so exactly one posedge commits. → RESP.
- RESP: rsp_valid=1 for one cycle with rsp_rdata/rsp_err. → IDLE. rsp_rdata/rsp_err hold until the next RESP.
- Latency (accept edge = cycle 0):
  - load: rsp_valid in cycle 2
  - store: rsp_valid in cycle 3
  - error: rsp_valid in cycle 1
  - Throughput is one request per 3 (load) or 4 (store) cycles.
- Non-pipelined: req_ready=0 outside IDLE. Requests presented then are not accepted and must be held by the requester.
- mem_r_wr=0 is legal only in WRITE. Any other state with mem_r_wr=0 is an assertion failure.
- Reset during WRITE before the edge: no write commits. Reset after the commit edge: the write persists and no response is issued.
- Back-to-back store then load to the same word: the load returns the merged value (write committed before ACCESS of the next request).

Decomposition:
- Shared package lsu_pkg: funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5); state enum (IDLE, ACCESS, WRITE, RESP); MEM_READ=1'b1, MEM_WRITE=1'b0.
- One natural sub-module, lsu_lane_fmt (combinational). Load path: word + addr[1:0] + funct3 → extended data. Store path: old word + wdata + addr[1:0] + funct3 → merged word. The FSM stays in lsu_dmem_ctrl.

Test Plan:
- Reset: rst_n=0 mid-WRITE → mem_r_wr=1 asynchronously, state IDLE, rsp_valid=0, and the targeted word stays unchanged.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → mem_daddr=4, one cycle of mem_r_wr=0, rsp_rdata=0xDEADBEEF at cycle 2 of the load.
- SB addr 0x13 wdata 0x000000A5 over word 0x11223344 → memory word becomes 0xA5223344. Then LB 0x13 → 0xFFFFFFA5, and LBU 0x13 → 0x000000A5.
- SH addr 0x0 wdata 0x8001 over 0x11223344 → 0x11228001. LH 0x0 → 0xFFFF8001, LHU 0x2 → 0x00001122.
- Errors, each giving rsp_err=1 at cycle 1 with mem_r_wr never 0:
  - LW 0x2
  - SH 0x5
  - funct3=3 load
  - SW to 0x1000 (ADDR_W=10)
- Backpressure: req_valid held high continuously → req_ready=1 only in IDLE. Exactly one acceptance per 3 cycles for loads and 4 for stores, with no dropped or duplicated requests.
